condiciona_entrada: RTL and testbench

- Upstream conditioning stage for the processor's data-input unit.
- Takes raw board inputs: an 18-bit switch bank and the active-low ENTER push-button.
- Synchronises both to `clock` and debounces the button.
- Delivers a clean switch word, a debounced `enter` level, a one-cycle press pulse and a switch snapshot taken at the press. The input unit consumes these directly.

---
 rtl/condiciona_entrada_pkg.sv | 7 +
 rtl/condiciona_entrada_debounce_bit.sv | 76 +++++++
 rtl/condiciona_entrada.sv | 69 ++++++
 tb/tb_condiciona_entrada.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/condiciona_entrada_pkg.sv
// condiciona_pkg: shared state type and default sizing for the input conditioning stage.
package condiciona_pkg;
    localparam int DATA_W_DEF          = 18;
    localparam int DEBOUNCE_CYCLES_DEF = 500000;
    localparam int CNT_W_DEF           = 24;
    typedef enum logic [1:0] {SOLTO, CONF_PRESS, PRESSIONADO, CONF_SOLTA} estado_t;
endpackage

// File: rtl/condiciona_entrada_debounce_bit.sv
// debounce_bit: synchronises an active-low button, debounces it and captures a data word on each press.
module debounce_bit
    import condiciona_pkg::*;
#(
    parameter int W     = DATA_W_DEF,
    parameter int N     = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         key_raw,
    input  logic [W-1:0] dado,
    output logic         nivel,
    output logic         pulso,
    output logic [W-1:0] captura
);
    localparam logic [CNT_W-1:0] FIM = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] UM  = CNT_W'(1);
    logic             k0, k1, key_s;
    estado_t          estado;
    logic [CNT_W-1:0] cnt;
    assign key_s = ~k1;
    // level, pulse and capture are all updated on the same edge as the state
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            k0      <= 1'b1;
            k1      <= 1'b1;
            estado  <= SOLTO;
            cnt     <= '0;
            nivel   <= 1'b0;
            pulso   <= 1'b0;
            captura <= '0;
        end else begin
            k0    <= key_raw;
            k1    <= k0;
            pulso <= 1'b0;
            case (estado)
                SOLTO: if (key_s) begin
                    estado <= CONF_PRESS;
                    cnt    <= UM;
                end
                CONF_PRESS: if (!key_s) begin
                    estado <= SOLTO;
                    cnt    <= '0;
                end else if (cnt == FIM) begin
                    estado  <= PRESSIONADO;
                    cnt     <= '0;
                    nivel   <= 1'b1;
                    pulso   <= 1'b1;
                    captura <= dado;
                end else begin
                    cnt <= cnt + UM;
                end
                PRESSIONADO: if (!key_s) begin
                    estado <= CONF_SOLTA;
                    cnt    <= UM;
                end
                CONF_SOLTA: if (key_s) begin
                    estado <= PRESSIONADO;
                    cnt    <= '0;
                end else if (cnt == FIM) begin
                    estado <= SOLTO;
                    cnt    <= '0;
                    nivel  <= 1'b0;
                end else begin
                    cnt <= cnt + UM;
                end
                default: begin
                    estado <= SOLTO;
                    cnt    <= '0;
                    nivel  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: rtl/condiciona_entrada.sv
// condiciona_entrada: synchronises switches and ENTER, debounces ENTER, captures switches on press.
// Define CONDICIONA_CHAVES_DEBOUNCE_EN to also require a stable switch word before it propagates.
module condiciona_entrada
    import condiciona_pkg::*;
#(
    parameter int DATA_W          = DATA_W_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [DATA_W-1:0] chaves_raw,
    input  logic              key_raw,
    output logic [DATA_W-1:0] chaves,
    output logic              enter,
    output logic              enter_pulso,
    output logic [DATA_W-1:0] chaves_captura
);
    logic [DATA_W-1:0] s0, s1;
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s0 <= '0;
            s1 <= '0;
        end else begin
            s0 <= chaves_raw;
            s1 <= s0;
        end
    end
`ifdef CONDICIONA_CHAVES_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] FIM = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] UM  = CNT_W'(1);
    logic [DATA_W-1:0] cand;
    logic [CNT_W-1:0]  cnt;
    // cand tracks the word being timed; any new value restarts the count
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            chaves <= '0;
            cand   <= '0;
            cnt    <= '0;
        end else if (s1 == chaves) begin
            cand <= s1;
            cnt  <= '0;
        end else if (s1 != cand || cnt == '0) begin
            cand <= s1;
            cnt  <= UM;
        end else if (cnt == FIM) begin
            chaves <= s1;
            cnt    <= '0;
        end else begin
            cnt <= cnt + UM;
        end
    end
`else
    assign chaves = s1;
`endif
    debounce_bit #(
        .W    (DATA_W),
        .N    (DEBOUNCE_CYCLES),
        .CNT_W(CNT_W)
    ) u_key (
        .clock  (clock),
        .resetn (resetn),
        .key_raw(key_raw),
        .dado   (chaves),
        .nivel  (enter),
        .pulso  (enter_pulso),
        .captura(chaves_captura)
    );
endmodule

// File: tb/tb_condiciona_entrada.sv
// tb_condiciona_entrada: directed checks of synchronisation, debounce, press pulse and capture.
module tb_condiciona_entrada;
    localparam int DW = 18;
    localparam int N  = 4;
`ifdef CONDICIONA_CHAVES_DEBOUNCE_EN
    localparam logic [DW-1:0] CAP_RST = '0;
`else
    localparam logic [DW-1:0] CAP_RST_ALL = 18'h3FFFF;
    localparam logic [DW-1:0] CAP_RST = CAP_RST_ALL;
`endif
    logic          clock = 0;
    logic          resetn = 0;
    logic [DW-1:0] chaves_raw = '0;
    logic          key_raw = 1;
    logic [DW-1:0] chaves, chaves_captura;
    logic          enter, enter_pulso;
    int            total = 0, bad = 0, npulse = 0, np0;
    logic          seen;

    condiciona_entrada #(.DATA_W(DW), .DEBOUNCE_CYCLES(N), .CNT_W(4)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .chaves_raw    (chaves_raw),
        .key_raw       (key_raw),
        .chaves        (chaves),
        .enter         (enter),
        .enter_pulso   (enter_pulso),
        .chaves_captura(chaves_captura)
    );

    always #5 clock = ~clock;
    always @(negedge clock) if (enter_pulso) npulse++;

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    initial begin
        key_raw    = 0;
        chaves_raw = 18'h3FFFF;
        step(3);
        chk("rst_chaves", 32'(chaves), 0);
        chk("rst_enter", 32'(enter), 0);
        chk("rst_pulso", 32'(enter_pulso), 0);
        chk("rst_cap", 32'(chaves_captura), 0);
        resetn = 1;
        step(5);
        chk("held_enter_early", 32'(enter), 0);
        step(1);
        chk("held_enter", 32'(enter), 1);
        chk("held_pulso", 32'(enter_pulso), 1);
        chk("held_cap", 32'(chaves_captura), 32'(CAP_RST));
        chk("held_chaves", 32'(chaves), 32'h3FFFF);
        step(1);
        chk("held_pulso_end", 32'(enter_pulso), 0);
        chk("held_enter_stay", 32'(enter), 1);
        key_raw = 1;
        step(5);
        chk("rel_enter_early", 32'(enter), 1);
        step(1);
        chk("rel_enter", 32'(enter), 0);
        step(3);
        seen    = 0;
        key_raw = 0;
        for (int i = 0; i < 3; i++) begin step(1); seen |= enter | enter_pulso; end
        key_raw = 1;
        for (int i = 0; i < 8; i++) begin step(1); seen |= enter | enter_pulso; end
        chk("bounce", 32'(seen), 0);
        chaves_raw = 18'h00A5A;
        step(1);
        chk("sync_lat1", 32'(chaves), 32'h3FFFF);
        step(7);
        chk("chaves_a5a", 32'(chaves), 32'h00A5A);
        np0     = npulse;
        key_raw = 0;
        step(20);
        chk("press_pulses", 32'(npulse - np0), 1);
        chk("press_cap", 32'(chaves_captura), 32'h00A5A);
        chk("press_enter", 32'(enter), 1);
        seen    = 0;
        key_raw = 1;
        for (int i = 0; i < 2; i++) begin step(1); seen |= ~enter; end
        key_raw = 0;
        for (int i = 0; i < 10; i++) begin step(1); seen |= ~enter; end
        chk("glitch_enter", 32'(seen), 0);
        chk("glitch_pulses", 32'(npulse - np0), 1);
`ifdef CONDICIONA_CHAVES_DEBOUNCE_EN
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            chaves_raw = (i % 2 == 0) ? 18'h1 : 18'h2;
            step(1); seen |= (chaves != 18'h00A5A);
            step(1); seen |= (chaves != 18'h00A5A);
        end
        chk("sw_toggle_hold", 32'(seen), 0);
        chaves_raw = 18'h2;
        step(5);
        chk("sw_early", 32'(chaves), 32'h00A5A);
        step(1);
        chk("sw_settled", 32'(chaves), 32'h2);
        chaves_raw = 18'h00A5A;
        step(8);
`endif
        key_raw = 1;
        step(5);
        chk("rel2_enter_early", 32'(enter), 1);
        step(1);
        chk("rel2_enter", 32'(enter), 0);
        chk("rel2_pulses", 32'(npulse - np0), 1);
        step(3);
        key_raw = 0;
        step(4);
        resetn = 0;
        #1;
        chk("midrst_enter", 32'(enter), 0);
        chk("midrst_pulso", 32'(enter_pulso), 0);
        chk("midrst_chaves", 32'(chaves), 0);
        chk("midrst_cap", 32'(chaves_captura), 0);
        step(2);
        resetn = 1;
        step(5);
        chk("midrst_enter_early", 32'(enter), 0);
        step(1);
        chk("midrst_enter_rise", 32'(enter), 1);
        chk("midrst_pulso_rise", 32'(enter_pulso), 1);
`ifdef CONDICIONA_CHAVES_DEBOUNCE_EN
        chk("midrst_cap_rise", 32'(chaves_captura), 0);
`else
        chk("midrst_cap_rise", 32'(chaves_captura), 32'h00A5A);
`endif
        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
